// File: rtl/gm_bist_pkg.sv
// Shared types and default tap masks for the gate-model BIST wrapper.
// The FSM encoding and default polynomials are kept here so the top and bench agree.
package gm_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [23:0] DEF_LFSR_POLY = 24'hE10000;
    localparam logic [9:0]  DEF_MISR_POLY = 10'h240;

endpackage

// File: rtl/gm_shift_xor.sv
// W-bit Fibonacci shift register with parallel XOR input, used as both the
// pattern LFSR (data tied low) and the response MISR (data = MUT outputs).
module gm_shift_xor #(
    parameter int           W    = 4,
    parameter logic [W-1:0] POLY = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] data,
    output logic [W-1:0] q
);

    function automatic logic fb_parity(input logic [W-1:0] v);
        return ^(v & POLY);
    endfunction

    // Shift state: load has priority over a shift step; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {W{1'b0}};
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= {q[W-2:0], fb_parity(q)} ^ data;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/gate_model_bist.sv
// BIST wrapper: LFSR stimulus into a combinational gate model, MISR compaction
// of its response, one pattern per APPLY/CAPTURE pair, with start/done handshake.
module gate_model_bist
    import gm_bist_pkg::*;
#(
    parameter int               IN_W      = 24,
    parameter int               OUT_W     = 10,
    parameter int               CNT_W     = 16,
    parameter logic [IN_W-1:0]  LFSR_POLY = IN_W'(DEF_LFSR_POLY),
    parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(DEF_MISR_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [IN_W-1:0]  seed,
    input  logic [CNT_W-1:0] n_patterns,
    output logic [IN_W-1:0]  pattern,
    input  logic [OUT_W-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] signature
);

    state_t           state_r;
    state_t           next_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] n_pat_r;
    logic [CNT_W-1:0] count_inc_s;
    logic [IN_W-1:0]  seed_fixed_s;
    logic             launch_s;
    logic             step_s;
    logic             busy_r;
    logic             done_r;

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    assign seed_fixed_s = (seed == {IN_W{1'b0}}) ? {{(IN_W-1){1'b0}}, 1'b1} : seed;
    assign count_inc_s  = count_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; abort takes precedence over capture completion.
    always_comb begin
        next_s   = state_r;
        launch_s = 1'b0;
        step_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    launch_s = 1'b1;
                    next_s   = (n_patterns == {CNT_W{1'b0}}) ? ST_DONE : ST_APPLY;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    next_s = ST_IDLE;
                end else begin
                    step_s = 1'b1;
                    next_s = (count_inc_s == n_pat_r) ? ST_DONE : ST_APPLY;
                end
            end
            ST_DONE: begin
                next_s = ST_IDLE;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // Pattern counter and run length captured at launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
            n_pat_r <= {CNT_W{1'b0}};
        end else if (launch_s) begin
            count_r <= {CNT_W{1'b0}};
            n_pat_r <= n_patterns;
        end else if (step_s) begin
            count_r <= count_inc_s;
            n_pat_r <= n_pat_r;
        end else begin
            count_r <= count_r;
            n_pat_r <= n_pat_r;
        end
    end

    // Status flags registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_s == ST_APPLY) || (next_s == ST_CAPTURE);
            done_r <= (next_s == ST_DONE);
        end
    end

    gm_shift_xor #(
        .W    (IN_W),
        .POLY (LFSR_POLY)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (launch_s),
        .load_val (seed_fixed_s),
        .en       (step_s),
        .data     ({IN_W{1'b0}}),
        .q        (pattern)
    );

    gm_shift_xor #(
        .W    (OUT_W),
        .POLY (MISR_POLY)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (launch_s),
        .load_val ({OUT_W{1'b0}}),
        .en       (step_s),
        .data     (resp),
        .q        (signature)
    );

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_gate_model_bist.sv
// Self-checking bench for gate_model_bist (IN_W=4, OUT_W=4, LFSR taps 1100, MISR taps 1001).
// Expected APPLY patterns and signatures are queued at launch and popped as the DUT applies them.
module tb_gate_model_bist;

    localparam int IN_W  = 4;
    localparam int OUT_W = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [IN_W-1:0]  seed;
    logic [CNT_W-1:0] n_patterns;
    logic [IN_W-1:0]  pattern;
    logic [OUT_W-1:0] resp;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] signature;

    int resp_mode = 0;
    int n_pass    = 0;
    int n_total   = 0;

    logic [IN_W-1:0]  exp_pat_q[$];
    logic [OUT_W-1:0] exp_sig_q[$];

    gate_model_bist #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .CNT_W     (CNT_W),
        .LFSR_POLY (4'b1100),
        .MISR_POLY (4'b1001)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .seed       (seed),
        .n_patterns (n_patterns),
        .pattern    (pattern),
        .resp       (resp),
        .busy       (busy),
        .done       (done),
        .signature  (signature)
    );

    always #5 clk = ~clk;

    // Stand-in model under test: response selected by the scenario.
    always_comb begin
        case (resp_mode)
            0:       resp = 4'b0000;
            1:       resp = 4'b0001;
            2:       resp = pattern;
            default: resp = 4'b0000;
        endcase
    end

    function automatic logic [3:0] lfsr_next(input logic [3:0] p);
        return {p[2:0], p[3] ^ p[2]};
    endfunction

    function automatic logic [3:0] misr_next(input logic [3:0] s, input logic [3:0] r);
        return {s[2:0], s[3] ^ s[0]} ^ r;
    endfunction

    function automatic logic [3:0] model_resp(input int mode, input logic [3:0] p);
        case (mode)
            1:       return 4'b0001;
            2:       return p;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic run_and_check(input string name, input logic [3:0] s, input int n, input int mode);
        logic [3:0] p;
        logic [3:0] sg;
        logic [3:0] ep;
        logic [3:0] es;
        int done_k;
        int busy_cnt;
        resp_mode = mode;
        p  = (s == 4'b0000) ? 4'b0001 : s;
        sg = 4'b0000;
        exp_pat_q.delete();
        exp_sig_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_pat_q.push_back(p);
            exp_sig_q.push_back(sg);
            sg = misr_next(sg, model_resp(mode, p));
            p  = lfsr_next(p);
        end
        @(negedge clk);
        seed       = s;
        n_patterns = CNT_W'(n);
        start      = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_k   = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 2 * n + 10; k++) begin
            if (done) begin
                done_k = k;
                break;
            end
            if (busy) busy_cnt++;
            if (busy && (k % 2 == 1)) begin
                n_total++;
                if (exp_pat_q.size() == 0) begin
                    $display("FAIL %s extra_apply: cycle %0d pattern %b, no pattern expected", name, k, pattern);
                end else begin
                    ep = exp_pat_q.pop_front();
                    es = exp_sig_q.pop_front();
                    if (pattern !== ep) $display("FAIL %s apply_pattern: cycle %0d got %b want %b", name, k, pattern, ep);
                    else n_pass++;
                    n_total++;
                    if (signature !== es) $display("FAIL %s apply_signature: cycle %0d got %b want %b", name, k, signature, es);
                    else n_pass++;
                end
            end
            @(negedge clk);
        end
        n_total++;
        if (done_k !== 2 * n + 1) $display("FAIL %s done_latency: got cycle %0d want %0d (0 = timeout)", name, done_k, 2 * n + 1);
        else n_pass++;
        n_total++;
        if (busy_cnt !== 2 * n) $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, 2 * n);
        else n_pass++;
        n_total++;
        if (exp_pat_q.size() !== 0) $display("FAIL %s missing_applies: got %0d left want 0", name, exp_pat_q.size());
        else n_pass++;
        n_total++;
        if (signature !== sg) $display("FAIL %s final_signature: got %b want %b", name, signature, sg);
        else n_pass++;
        n_total++;
        if (pattern !== p) $display("FAIL %s final_pattern: got %b want %b", name, pattern, p);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done !== 1'b0) $display("FAIL %s done_width: got %b want 0 one cycle later", name, done);
        else n_pass++;
        n_total++;
        if (signature !== sg) $display("FAIL %s idle_hold_signature: got %b want %b", name, signature, sg);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        seed       = 4'b0000;
        n_patterns = 16'd0;
        #12;
        n_total++;
        if ({pattern, signature, busy, done} !== 10'b0) $display("FAIL reset_outputs: got %b want 0", {pattern, signature, busy, done});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({pattern, signature, busy, done} !== 10'b0) $display("FAIL reset_idle: got %b want 0", {pattern, signature, busy, done});
        else n_pass++;
    endtask

    task automatic test_abort();
        resp_mode = 0;
        @(negedge clk);
        seed = 4'b0001; n_patterns = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        seed = 4'b0101; n_patterns = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (pattern !== 4'b0010) $display("FAIL abort_start_ignored: pattern got %b want 0010", pattern);
        else n_pass++;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_total++;
        if (busy !== 1'b0) $display("FAIL abort_to_idle: busy got %b want 0", busy);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_total++;
            if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_no_done: cycle %0d done %b busy %b want 0 0", k, done, busy);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        resp_mode = 2;
        @(negedge clk);
        seed = 4'b0110; n_patterns = 16'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({pattern, signature, busy, done} !== 10'b0) $display("FAIL async_reset: got %b want 0", {pattern, signature, busy, done});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_total++;
            if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_back_idle: busy %b done %b want 0 0", busy, done);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        run_and_check("lfsr_seq", 4'b0001, 4, 0);
        run_and_check("misr_const", 4'b0001, 2, 1);
        run_and_check("period15", 4'b0001, 15, 2);
        run_and_check("seed_zero", 4'b0000, 1, 2);
        run_and_check("n_zero", 4'b1010, 0, 2);
        test_abort();
        run_and_check("after_abort", 4'b0011, 3, 2);
        test_async_reset();
        run_and_check("after_reset", 4'b1001, 5, 2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
